btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 23 ++
 rtl/btn_fsm.sv | 119 +++++++++++
 rtl/btn_debounce.sv | 33 +++
 tb/tb_btn_debounce.sv | 134 +++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared state encoding and default timing for the button debouncer.
package btn_pkg;

    // Per-button FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StPressWait   = 3'd1,
        StHeld        = 3'd2,
        StRepeat      = 3'd3,
        StReleaseWait = 3'd4
    } btn_state_e;

    // Counter width: wide enough for the 500 ms repeat delay at 100 MHz
    localparam int unsigned CntWidth = 26;

    // Default timing at 100 MHz
    localparam int unsigned DefDebounceCnt = 1000000;   // 10 ms
    localparam int unsigned DefRepeatDly   = 50000000;  // 500 ms
    localparam int unsigned DefRepeatRate  = 10000000;  // 100 ms

    localparam int unsigned NumButtons = 4;

endpackage

// File: rtl/btn_fsm.sv
// One button: 2-flop synchronizer, stable-cycle counter and debounce/repeat FSM.
module btn_fsm
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DefDebounceCnt,
    parameter int unsigned REPEAT_DLY   = DefRepeatDly,
    parameter int unsigned REPEAT_RATE  = DefRepeatRate
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic pulse
);

    // Terminal counts; every compare is equality at value-1 so the counter never wraps
    localparam logic [CntWidth-1:0] DbLast   = CntWidth'(DEBOUNCE_CNT - 1);
    localparam logic [CntWidth-1:0] DlyLast  = CntWidth'(REPEAT_DLY - 1);
    localparam logic [CntWidth-1:0] RateLast = CntWidth'(REPEAT_RATE - 1);

    logic                meta_q;
    logic                sync_q;
    btn_state_e          state_q;
    logic [CntWidth-1:0] cnt_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Debounce / auto-repeat FSM with registered level and strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            pulse <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sync_q) begin
                        state_q <= StPressWait;
                        cnt_q   <= '0;
                    end
                end
                StPressWait: begin
                    if (!sync_q) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == DbLast) begin
                        state_q <= StHeld;
                        cnt_q   <= '0;
                        level   <= 1'b1;
                        pulse   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHeld: begin
                    // Release wins over a repeat falling due in the same cycle
                    if (!sync_q) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= '0;
                    end else if (cnt_q == DlyLast) begin
                        // Saturate here until repeat is enabled
                        if (repeat_en) begin
                            state_q <= StRepeat;
                            cnt_q   <= '0;
                            pulse   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (!sync_q) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= '0;
                    end else if (!repeat_en) begin
                        state_q <= StHeld;
                        cnt_q   <= '0;
                    end else if (cnt_q == RateLast) begin
                        cnt_q <= '0;
                        pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StReleaseWait: begin
                    // Bounce on release: fall back to HELD without a new strobe
                    if (sync_q) begin
                        state_q <= StHeld;
                        cnt_q   <= '0;
                    end else if (cnt_q == DbLast) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        level   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    level   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Four independent debounced buttons {U, D, L, R} with optional auto-repeat.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DefDebounceCnt,
    parameter int unsigned REPEAT_DLY   = DefRepeatDly,
    parameter int unsigned REPEAT_RATE  = DefRepeatRate
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic [3:0] repeat_en,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse
);

    // One self-contained FSM per button
    for (genvar i = 0; i < NumButtons; i++) begin : g_btn
        btn_fsm #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .raw       (btn_raw[i]),
            .repeat_en (repeat_en[i]),
            .level     (btn_level[i]),
            .pulse     (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short timing (debounce 4, delay 10, rate 3).
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0;
    logic [3:0] repeat_en = 4'b0;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .DEBOUNCE_CNT (4),
        .REPEAT_DLY   (10),
        .REPEAT_RATE  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    typedef struct {
        logic [3:0] raw;
        logic [3:0] ren;
        logic [3:0] lvl;
        logic [3:0] pls;
    } vec_t;

    vec_t tbl[50];

    task automatic check(input string name, input int row, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    // One row: drive just after the rising edge, then move to the falling edge to sample
    task automatic drive(input logic r, input logic [3:0] raw, input logic [3:0] ren);
        @(posedge clk);
        #1;
        rst       = r;
        btn_raw   = raw;
        repeat_en = ren;
        @(negedge clk);
    endtask

    initial begin
        // Row i: inputs applied in cycle i, outputs expected in cycle i
        for (int i = 0; i < 30; i++) begin
            tbl[i].raw = (i < 20) ? 4'b0001 : 4'b0000;
            tbl[i].ren = 4'b0000;
            tbl[i].lvl = (i >= 7 && i < 27) ? 4'b0001 : 4'b0000;
            tbl[i].pls = (i == 7) ? 4'b0001 : 4'b0000;
        end
        for (int j = 0; j < 20; j++) begin
            tbl[30+j].raw = (j < 10) ? 4'b1111 : 4'b0000;
            tbl[30+j].ren = 4'b0000;
            tbl[30+j].lvl = (j >= 7 && j < 17) ? 4'b1111 : 4'b0000;
            tbl[30+j].pls = (j == 7) ? 4'b1111 : 4'b0000;
        end

        // Reset state
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0000, 4'b0000);
        check("reset_level", 0, btn_level, 4'b0000);
        check("reset_pulse", 0, btn_pulse, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0000, 4'b0000);
            check("idle_level", k, btn_level, 4'b0000);
            check("idle_pulse", k, btn_pulse, 4'b0000);
        end

        // Clean press on bit0, then all four buttons together
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, tbl[i].raw, tbl[i].ren);
            check("tbl_level", i, btn_level, tbl[i].lvl);
            check("tbl_pulse", i, btn_pulse, tbl[i].pls);
        end

        // Bounce on bit1: 1,0,1,0 then stable 1 from row 4 until row 16
        for (int k = 0; k < 24; k++) begin
            logic r1;
            r1 = (k < 4) ? (k % 2 == 0) : (k < 16);
            drive(1'b0, {2'b00, r1, 1'b0}, 4'b0000);
            check("bounce_level", k, btn_level, (k >= 11 && k < 23) ? 4'b0010 : 4'b0000);
            check("bounce_pulse", k, btn_pulse, (k == 11) ? 4'b0010 : 4'b0000);
        end

        // Auto-repeat on bit2: held rows 0..39
        for (int k = 0; k < 50; k++) begin
            logic p;
            p = (k == 7) || (k >= 17 && k <= 41 && ((k - 17) % 3 == 0));
            drive(1'b0, (k < 40) ? 4'b0100 : 4'b0000, 4'b0100);
            check("repeat_level", k, btn_level, (k >= 7 && k < 47) ? 4'b0100 : 4'b0000);
            check("repeat_pulse", k, btn_pulse, p ? 4'b0100 : 4'b0000);
        end

        // Release bounce on bit3: low for rows 20,21, final release at row 35
        for (int k = 0; k < 45; k++) begin
            logic r3;
            r3 = (k < 20) || (k >= 22 && k < 35);
            drive(1'b0, {r3, 3'b000}, 4'b0000);
            check("relbounce_level", k, btn_level, (k >= 7 && k < 42) ? 4'b1000 : 4'b0000);
            check("relbounce_pulse", k, btn_pulse, (k == 7) ? 4'b1000 : 4'b0000);
        end

        // Reset while bit0 is in REPEAT; button stays held and must requalify
        for (int k = 0; k < 41; k++) begin
            logic       lv;
            logic       pl;
            logic [3:0] ren;
            lv  = (k >= 7 && k < 20) || (k >= 27 && k < 38);
            pl  = (k == 7) || (k == 17) || (k == 27);
            ren = (k <= 30) ? 4'b0001 : 4'b0000;
            drive(k == 19, (k <= 30) ? 4'b0001 : 4'b0000, ren);
            check("rstmid_level", k, btn_level, lv ? 4'b0001 : 4'b0000);
            check("rstmid_pulse", k, btn_pulse, pl ? 4'b0001 : 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
